// File: rtl/mem_request_arbiter.sv
// ----------------------------------------------------------------------------
// mem_request_arbiter
//
// Responder end of the cache miss path. Takes icache fill requests and dcache
// read/write requests, serialises them onto a single-port RAM, and returns the
// wait/load handshake to each cache.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin between icache and dcache. A 1-bit
//                           pointer moves to the other side after every
//                           completion.
//              undefined -> fixed priority, dcache always wins a tie.
//
// Parameters:
//   WATCHDOG  cycles allowed in an access state before a forced error
//             completion (must be >= 2)
//   ERR_WORD  load value returned on a watchdog completion
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   iREN, iaddr                icache request (held until iwait=0)
//   iwait, iload               icache handshake / fill data
//   dREN, dWEN, daddr, dstore  dcache request (dWEN wins over dREN)
//   dwait, dload               dcache handshake / read data
//   ramREN, ramWEN, ramaddr,
//   ramstore                   RAM request strobes, address and write data
//   ramload, ramstate          RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   memerr                     sticky watchdog error flag
// ----------------------------------------------------------------------------
module mem_request_arbiter #(
    parameter int          WATCHDOG = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        memerr
);

    localparam int          WD_W       = $clog2(WATCHDOG) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_memerr;

    logic              w_ireq;
    logic              w_dreq;
    logic              w_pick_d;
    logic              w_wd_last;
    logic              w_cmpl_i;
    logic              w_cmpl_d;
    logic              w_wd_fire;

    assign w_ireq    = iREN;
    assign w_dreq    = dREN | dWEN;
    assign w_wd_last = (r_wdog == WD_LAST);
    assign memerr    = r_memerr;

`ifdef ARB_RR_EN
    // Pointer high means the dcache side owns the next tie.
    logic r_rr_ptr;

    assign w_pick_d = w_dreq & (~w_ireq | r_rr_ptr);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr <= 1'b1;
        end else if (w_cmpl_i) begin
            r_rr_ptr <= 1'b1;
        end else if (w_cmpl_d) begin
            r_rr_ptr <= 1'b0;
        end
    end
`else
    assign w_pick_d = w_dreq;
`endif

    // State register, watchdog counter and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_wdog   <= '0;
            r_memerr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Counter sits at zero in IDLE so every grant starts a fresh count.
            if (r_state == S_IDLE) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_wd_fire) begin
                r_memerr <= 1'b1;
            end
        end
    end

    // Next state and all cache/RAM outputs. Strobes follow the held cache
    // inputs combinationally so a withdrawn request drops them the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        w_cmpl_i    = 1'b0;
        w_cmpl_d    = 1'b0;
        w_wd_fire   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_state_nxt = S_DACC;
                end else if (w_ireq) begin
                    w_state_nxt = S_IACC;
                end
            end

            S_IACC: begin
                if (!iREN) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    // A real ACCESS in the last watchdog cycle still wins.
                    if (ramstate == RAM_ACCESS) begin
                        iwait       = 1'b0;
                        iload       = ramload;
                        w_cmpl_i    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_wd_last) begin
                        iwait       = 1'b0;
                        iload       = ERR_WORD;
                        w_cmpl_i    = 1'b1;
                        w_wd_fire   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DACC: begin
                if (!w_dreq) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramWEN   = dWEN;
                    ramstore = dstore;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait       = 1'b0;
                        dload       = dWEN ? 32'd0 : ramload;
                        w_cmpl_d    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_wd_last) begin
                        dwait       = 1'b0;
                        dload       = ERR_WORD;
                        w_cmpl_d    = 1'b1;
                        w_wd_fire   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_request_arbiter #(
        .WATCHDOG (8),
        .ERR_WORD (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Clear all requests, spend one idle cycle.
    task automatic idle();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = ST_FREE;
        #1;
        cyc();
    endtask

    initial begin
        nRST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = ST_FREE;
        #1 nRST = 1'b0;
        #1;
        // Reset state
        chk("rst_iwait",   32'(iwait), 32'd1);
        chk("rst_dwait",   32'(dwait), 32'd1);
        chk("rst_iload",   iload, 32'd0);
        chk("rst_dload",   dload, 32'd0);
        chk("rst_ramREN",  32'(ramREN), 32'd0);
        chk("rst_ramWEN",  32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_memerr",  32'(memerr), 32'd0);
        cyc();
        nRST = 1'b1;

        // Simultaneous requests
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
`ifdef ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            ramstate = ST_FREE;
            #1;
            chk("t3_idle_ren", 32'(ramREN), 32'd0);
            cyc();
            ramstate = ST_ACCESS; ramload = 32'(k + 16);
            #1;
            chk("t3_rr_addr", ramaddr, (k % 2 == 0) ? 32'h300 : 32'h200);
            if (k % 2 == 0) begin
                chk("t3_rr_dwait", 32'(dwait), 32'd0);
                chk("t3_rr_dload", dload, 32'(k + 16));
            end else begin
                chk("t3_rr_iwait", 32'(iwait), 32'd0);
                chk("t3_rr_iload", iload, 32'(k + 16));
            end
            cyc();
        end
`else
        ramstate = ST_FREE;
        #1;
        chk("t3_idle_ren", 32'(ramREN), 32'd0);
        cyc();
        ramstate = ST_ACCESS; ramload = 32'h11;
        #1;
        chk("t3_d_addr",  ramaddr, 32'h300);
        chk("t3_d_ren",   32'(ramREN), 32'd1);
        chk("t3_d_dwait", 32'(dwait), 32'd0);
        chk("t3_d_dload", dload, 32'h11);
        chk("t3_d_iwait", 32'(iwait), 32'd1);
        cyc();
        dREN = 1'b0; ramstate = ST_FREE;
        #1;
        chk("t3_gap_ren",   32'(ramREN), 32'd0);
        chk("t3_gap_iwait", 32'(iwait), 32'd1);
        cyc();
        ramstate = ST_ACCESS; ramload = 32'h22;
        #1;
        chk("t3_i_addr",  ramaddr, 32'h200);
        chk("t3_i_iwait", 32'(iwait), 32'd0);
        chk("t3_i_iload", iload, 32'h22);
        cyc();
`endif
        idle();

        // Instruction fill, ACCESS on second strobe cycle
        iREN = 1'b1; iaddr = 32'h40;
        #1;
        chk("t1_req_iwait", 32'(iwait), 32'd1);
        chk("t1_req_ren",   32'(ramREN), 32'd0);
        cyc();
        ramstate = ST_BUSY;
        #1;
        chk("t1_s1_ren",   32'(ramREN), 32'd1);
        chk("t1_s1_addr",  ramaddr, 32'h40);
        chk("t1_s1_iwait", 32'(iwait), 32'd1);
        cyc();
        ramstate = ST_ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk("t1_done_iwait", 32'(iwait), 32'd0);
        chk("t1_done_iload", iload, 32'hDEADBEEF);
        chk("t1_done_dwait", 32'(dwait), 32'd1);
        cyc();
        iREN = 1'b0; ramstate = ST_FREE;
        #1;
        chk("t1_after_iwait", 32'(iwait), 32'd1);
        chk("t1_after_iload", iload, 32'd0);
        cyc();

        // Data write with dREN also high, immediate ACCESS
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
        #1;
        chk("t2_req_wen",   32'(ramWEN), 32'd0);
        chk("t2_req_dwait", 32'(dwait), 32'd1);
        cyc();
        ramstate = ST_ACCESS; ramload = 32'hCAFEF00D;
        #1;
        chk("t2_wen",   32'(ramWEN), 32'd1);
        chk("t2_ren",   32'(ramREN), 32'd0);
        chk("t2_store", ramstore, 32'h12345678);
        chk("t2_addr",  ramaddr, 32'h100);
        chk("t2_dwait", 32'(dwait), 32'd0);
        chk("t2_dload", dload, 32'd0);
        cyc();
        dWEN = 1'b0; dREN = 1'b0; ramstate = ST_FREE;
        #1;
        chk("t2_after_dwait", 32'(dwait), 32'd1);
        chk("t2_after_wen",   32'(ramWEN), 32'd0);
        cyc();

        // ACCESS on the final watchdog cycle returns real data
        dREN = 1'b1; daddr = 32'h500;
        #1;
        cyc();
        for (int i = 1; i < 8; i++) begin
            ramstate = (i % 2 == 1) ? ST_BUSY : ST_ERROR;
            #1;
            chk("t4a_wait", 32'(dwait), 32'd1);
            cyc();
        end
        ramstate = ST_ACCESS; ramload = 32'h77;
        #1;
        chk("t4a_dwait", 32'(dwait), 32'd0);
        chk("t4a_dload", dload, 32'h77);
        cyc();
        dREN = 1'b0; ramstate = ST_FREE;
        #1;
        chk("t4a_memerr", 32'(memerr), 32'd0);
        cyc();

        // Watchdog fires on the 8th DACC cycle
        dREN = 1'b1; daddr = 32'h500;
        #1;
        cyc();
        for (int i = 1; i < 8; i++) begin
            ramstate = ST_BUSY;
            #1;
            chk("t4b_wait", 32'(dwait), 32'd1);
            chk("t4b_ren",  32'(ramREN), 32'd1);
            cyc();
        end
        #1;
        chk("t4b_dwait",     32'(dwait), 32'd0);
        chk("t4b_dload",     dload, 32'hBAD1BAD1);
        chk("t4b_memerr_lo", 32'(memerr), 32'd0);
        cyc();
        dREN = 1'b0; ramstate = ST_FREE;
        #1;
        chk("t4b_memerr_hi", 32'(memerr), 32'd1);
        chk("t4b_after_dwait", 32'(dwait), 32'd1);
        cyc();
        #1;
        chk("t4b_memerr_sticky", 32'(memerr), 32'd1);
        cyc();

        // Reset pulse in the middle of a DACC
        dREN = 1'b1; daddr = 32'h600; ramstate = ST_BUSY;
        #1;
        cyc();
        #1;
        chk("t5_pre_ren", 32'(ramREN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("t5_rst_ren",    32'(ramREN), 32'd0);
        chk("t5_rst_addr",   ramaddr, 32'd0);
        chk("t5_rst_dwait",  32'(dwait), 32'd1);
        chk("t5_rst_iwait",  32'(iwait), 32'd1);
        chk("t5_rst_memerr", 32'(memerr), 32'd0);
        cyc();
        nRST = 1'b1;
        #1;
        chk("t5_rel_ren",   32'(ramREN), 32'd0);
        chk("t5_rel_dwait", 32'(dwait), 32'd1);
        cyc();
        ramstate = ST_ACCESS; ramload = 32'h66;
        #1;
        chk("t5_regrant_addr",  ramaddr, 32'h600);
        chk("t5_regrant_dwait", 32'(dwait), 32'd0);
        chk("t5_regrant_dload", dload, 32'h66);
        cyc();
        idle();

        // Withdrawal of dREN before ACCESS
        dREN = 1'b1; daddr = 32'h700; ramstate = ST_BUSY;
        #1;
        cyc();
        #1;
        chk("t6_acc_ren",   32'(ramREN), 32'd1);
        chk("t6_acc_dwait", 32'(dwait), 32'd1);
        cyc();
        dREN = 1'b0; ramstate = ST_ACCESS; ramload = 32'h99;
        #1;
        chk("t6_drop_ren",   32'(ramREN), 32'd0);
        chk("t6_drop_dwait", 32'(dwait), 32'd1);
        cyc();
        dREN = 1'b1; ramstate = ST_FREE;
        #1;
        chk("t6_idle_ren", 32'(ramREN), 32'd0);
        cyc();
        ramstate = ST_ACCESS;
        #1;
        chk("t6_regrant_ren",   32'(ramREN), 32'd1);
        chk("t6_regrant_dwait", 32'(dwait), 32'd0);
        cyc();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
